// File: rtl/jtopl_stereo_acc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : jtopl_stereo_acc_pkg
// Purpose  : Shared jtopl constants and helpers: OPL slot count, accumulator
//            width derivation and a generic signed saturation function.
// Revision : 1.0 - initial stereo accumulator release
// ============================================================================
package jtopl_stereo_acc_pkg;

  // Operator slots in one OPL frame
  localparam int c_OPL_SLOTS = 18;

  // Accumulator width able to hold slots * 2 (rhythm gain) * max|op| with
  // no wrap: one extra bit per doubling of 2*slots over the operator width.
  function automatic int acc_width(input int opw, input int slots);
    return opw + $clog2(2 * slots);
  endfunction

  // Clamp a signed value into the range of a signed word of the given width.
  function automatic logic signed [63:0] sat(input logic signed [63:0] value,
                                             input int                 width);
    logic signed [63:0] v_max;
    logic signed [63:0] v_min;
    v_max = (64'sd1 <<< (width - 1)) - 64'sd1;
    v_min = -(64'sd1 <<< (width - 1));
    if (value > v_max) begin
      return v_max;
    end else if (value < v_min) begin
      return v_min;
    end else begin
      return value;
    end
  endfunction

endpackage
`default_nettype wire

// File: rtl/jtopl_stereo_acc_if.sv
`default_nettype none
// ============================================================================
// Module   : jtopl_stereo_acc_if
// Purpose  : Slot input bus from the operator stage and stereo sample bus
//            towards the sound output, bundled for the stereo accumulator.
// Revision : 1.0 - initial stereo accumulator release
// ============================================================================
interface jtopl_stereo_acc_if #(
  parameter int OPW  = 14,
  parameter int OUTW = 16
);

  // Per-slot operator information
  logic                   cenop;
  logic signed [OPW-1:0]  op_result;
  logic                   zero;
  logic                   op;
  logic                   con;
  logic                   pan_l;
  logic                   pan_r;
  logic                   rhy;

  // Latched stereo sample and status
  logic signed [OUTW-1:0] snd_l;
  logic signed [OUTW-1:0] snd_r;
  logic                   sample_vld;
  logic                   clip;
  logic                   frame_err;

  // Operator-stage side
  modport master (
    output cenop, op_result, zero, op, con, pan_l, pan_r, rhy,
    input  snd_l, snd_r, sample_vld, clip, frame_err
  );

  // Accumulator side
  modport slave (
    input  cenop, op_result, zero, op, con, pan_l, pan_r, rhy,
    output snd_l, snd_r, sample_vld, clip, frame_err
  );

endinterface
`default_nettype wire

// File: rtl/jtopl_sat_latch.sv
`default_nettype none
// ============================================================================
// Module   : jtopl_sat_latch
// Purpose  : One channel of the stereo accumulator. Sums slot terms over a
//            frame and, on the frame boundary, latches the saturated sum while
//            restarting the accumulator with the boundary slot's own term.
// Revision : 1.0 - initial stereo accumulator release
// ============================================================================
module jtopl_sat_latch
  import jtopl_stereo_acc_pkg::*;
#(
  parameter int ACCW = 20,
  parameter int OUTW = 16
) (
  input  wire logic                   clk,
  input  wire logic                   rst,       // asynchronous, active-low
  input  wire logic                   en,        // slot advance (cenop)
  input  wire logic                   load,      // frame boundary (cenop & zero)
  input  wire logic signed [ACCW-1:0] term,
  output      logic signed [OUTW-1:0] snd,
  output      logic                   overflow   // current sum exceeds OUTW range
);

  logic signed [ACCW-1:0] r_acc;
  logic signed [OUTW-1:0] r_snd;
  logic signed [63:0]     w_sat;

  assign w_sat    = sat(64'(r_acc), OUTW);
  assign overflow = (w_sat != 64'(r_acc));
  assign snd      = r_snd;

  // Accumulate per slot; on the boundary slot latch the clamped frame sum
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_acc <= '0;
      r_snd <= '0;
    end else if (load) begin
      r_snd <= OUTW'(w_sat);
      r_acc <= term;
    end else if (en) begin
      r_acc <= r_acc + term;
    end
  end

endmodule
`default_nettype wire

// File: rtl/jtopl_stereo_acc.sv
`default_nettype none
// ============================================================================
// Module   : jtopl_stereo_acc
// Purpose  : Stereo OPL output accumulator. Masks modulator slots, applies
//            rhythm gain and panning, sums a frame per side, and latches
//            saturated samples with valid strobe, clip and frame-length flags.
// Revision : 1.0 - initial stereo accumulator release
// ============================================================================
module jtopl_stereo_acc
  import jtopl_stereo_acc_pkg::*;
#(
  parameter int OPW   = 14,
  parameter int OUTW  = 16,
  parameter int SLOTS = c_OPL_SLOTS,
  parameter int ACCW  = acc_width(OPW, SLOTS)
) (
  input  wire logic clk,
  input  wire logic rst,                 // asynchronous, active-low
  jtopl_stereo_acc_if.slave bus
);

  localparam int             CNTW    = $clog2(SLOTS + 1);
  localparam logic [CNTW-1:0] c_SLOTS = CNTW'(SLOTS);
  localparam logic [CNTW-1:0] c_ONE   = CNTW'(1);

  logic                   w_load;
  logic                   w_sum_en;
  logic signed [ACCW-1:0] w_op_ext;
  logic signed [ACCW-1:0] w_term;
  logic signed [ACCW-1:0] w_tl;
  logic signed [ACCW-1:0] w_tr;
  logic                   w_ovf_l;
  logic                   w_ovf_r;

  logic [CNTW-1:0]        r_cnt;
  logic                   r_first_frame;
  logic                   r_sample_vld;
  logic                   r_clip;
  logic                   r_frame_err;

  // zero only counts when the operator stage actually advances
  assign w_load   = bus.cenop & bus.zero;

  // Only carrier slots (or additive connections) reach the output
  assign w_sum_en = bus.op | bus.con;
  assign w_op_ext = {{(ACCW-OPW){bus.op_result[OPW-1]}}, bus.op_result};
  assign w_term   = w_sum_en ? (bus.rhy ? (w_op_ext <<< 1) : w_op_ext) : '0;
  assign w_tl     = bus.pan_l ? w_term : '0;
  assign w_tr     = bus.pan_r ? w_term : '0;

  jtopl_sat_latch #(
    .ACCW (ACCW),
    .OUTW (OUTW)
  ) u_left (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.cenop),
    .load     (w_load),
    .term     (w_tl),
    .snd      (bus.snd_l),
    .overflow (w_ovf_l)
  );

  jtopl_sat_latch #(
    .ACCW (ACCW),
    .OUTW (OUTW)
  ) u_right (
    .clk      (clk),
    .rst      (rst),
    .en       (bus.cenop),
    .load     (w_load),
    .term     (w_tr),
    .snd      (bus.snd_r),
    .overflow (w_ovf_r)
  );

  // Slot counter, frame-length check and clip flag, all gated by cenop
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt         <= '0;
      r_first_frame <= 1'b1;
      r_clip        <= 1'b0;
      r_frame_err   <= 1'b0;
    end else if (w_load) begin
      // The first boundary after reset closes no real frame, so skip the check
      if (!r_first_frame && (r_cnt != c_SLOTS)) begin
        r_frame_err <= 1'b1;
      end
      r_first_frame <= 1'b0;
      r_cnt         <= c_ONE;
      r_clip        <= w_ovf_l | w_ovf_r;
    end else if (bus.cenop) begin
      if (r_cnt != c_SLOTS) begin
        r_cnt <= r_cnt + c_ONE;
      end
    end
  end

  // Sample-valid strobe lasts exactly one clock after each latch
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sample_vld <= 1'b0;
    end else begin
      r_sample_vld <= w_load;
    end
  end

  assign bus.sample_vld = r_sample_vld;
  assign bus.clip       = r_clip;
  assign bus.frame_err  = r_frame_err;

endmodule
`default_nettype wire

// File: tb/tb_jtopl_stereo_acc.sv
`default_nettype none
// ============================================================================
// Module   : tb_jtopl_stereo_acc
// Purpose  : Directed-vector bench for the stereo OPL accumulator.
// Revision : 1.0 - initial stereo accumulator release
// ============================================================================
module tb_jtopl_stereo_acc;

  localparam int OPW   = 14;
  localparam int OUTW  = 16;
  localparam int SLOTS = 18;

  logic clk;
  logic rst;
  int   vectors;
  int   miscompares;

  jtopl_stereo_acc_if #(.OPW(OPW), .OUTW(OUTW)) bus ();

  jtopl_stereo_acc #(
    .OPW   (OPW),
    .OUTW  (OUTW),
    .SLOTS (SLOTS)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // 10 time-unit clock, rising edges at 5, 15, 25, ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag,
                     input logic signed [31:0] obs,
                     input logic signed [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one slot with cenop high, then sample 1 time unit after the edge
  task automatic slot(input logic z, input logic o, input logic cn,
                      input logic pl, input logic pr, input logic rh,
                      input int val);
    bus.cenop     = 1'b1;
    bus.zero      = z;
    bus.op        = o;
    bus.con       = cn;
    bus.pan_l     = pl;
    bus.pan_r     = pr;
    bus.rhy       = rh;
    bus.op_result = OPW'(val);
    @(posedge clk);
    #1;
    bus.cenop     = 1'b0;
    bus.zero      = 1'b0;
  endtask

  initial begin
    vectors       = 0;
    miscompares   = 0;
    rst           = 1'b0;
    bus.cenop     = 1'b0;
    bus.zero      = 1'b0;
    bus.op        = 1'b0;
    bus.con       = 1'b0;
    bus.pan_l     = 1'b0;
    bus.pan_r     = 1'b0;
    bus.rhy       = 1'b0;
    bus.op_result = '0;

    // Reset state
    #3;
    chk("rst_snd_l", bus.snd_l, 0);
    chk("rst_snd_r", bus.snd_r, 0);
    chk("rst_vld", bus.sample_vld, 0);
    chk("rst_clip", bus.clip, 0);
    chk("rst_ferr", bus.frame_err, 0);
    #19 rst = 1'b1;
    @(posedge clk);
    #1;

    // A: 18 x 100 on both sides; first zero latches cleared accumulators
    slot(1, 1, 0, 1, 1, 0, 100);
    chk("first_zero_snd_l", bus.snd_l, 0);
    chk("first_zero_vld", bus.sample_vld, 1);
    chk("first_zero_ferr", bus.frame_err, 0);
    slot(0, 1, 0, 1, 1, 0, 100);
    chk("vld_one_clk", bus.sample_vld, 0);
    for (int i = 2; i < SLOTS; i++) slot(0, 1, 0, 1, 1, 0, 100);

    // B: alternate masked modulator slots and left-only carriers of -50
    for (int i = 0; i < SLOTS; i++) begin
      if (i % 2 == 0) slot(i == 0, 0, 0, 1, 1, 0, -50);
      else            slot(0, 1, 0, 1, 0, 0, -50);
      if (i == 0) begin
        chk("basic_snd_l", bus.snd_l, 1800);
        chk("basic_snd_r", bus.snd_r, 1800);
        chk("basic_vld", bus.sample_vld, 1);
        chk("basic_clip", bus.clip, 0);
      end
    end

    // C: rhythm slot 5 of 1000, everything else zero
    for (int i = 0; i < SLOTS; i++) begin
      slot(i == 0, 1, 0, 1, 1, (i == 5), (i == 5) ? 1000 : 0);
      if (i == 0) begin
        chk("mask_snd_l", bus.snd_l, -450);
        chk("mask_snd_r", bus.snd_r, 0);
      end
    end

    // D: positive saturation, 18 x 8191 doubled
    for (int i = 0; i < SLOTS; i++) begin
      slot(i == 0, 1, 0, 1, 1, 1, 8191);
      if (i == 0) begin
        chk("rhy_snd_l", bus.snd_l, 2000);
        chk("rhy_snd_r", bus.snd_r, 2000);
        chk("rhy_clip", bus.clip, 0);
      end
    end

    // E: negative saturation, 18 x -8192 doubled
    for (int i = 0; i < SLOTS; i++) begin
      slot(i == 0, 1, 0, 1, 1, 1, -8192);
      if (i == 0) begin
        chk("satp_snd_l", bus.snd_l, 32767);
        chk("satp_snd_r", bus.snd_r, 32767);
        chk("satp_clip", bus.clip, 1);
      end
    end

    // F: normal frame again
    for (int i = 0; i < SLOTS; i++) begin
      slot(i == 0, 1, 0, 1, 1, 0, 100);
      if (i == 0) begin
        chk("satn_snd_l", bus.snd_l, -32768);
        chk("satn_snd_r", bus.snd_r, -32768);
        chk("satn_clip", bus.clip, 1);
      end
    end

    // G: short frame of 17 slots of 10
    for (int i = 0; i < SLOTS - 1; i++) begin
      slot(i == 0, 1, 0, 1, 1, 0, 10);
      if (i == 0) begin
        chk("norm_snd_l", bus.snd_l, 1800);
        chk("norm_clip", bus.clip, 0);
        chk("norm_ferr", bus.frame_err, 0);
      end
    end

    // H: good frame of 18 x 1 after the short one
    for (int i = 0; i < SLOTS; i++) begin
      slot(i == 0, 1, 0, 1, 1, 0, 1);
      if (i == 0) begin
        chk("short_snd_l", bus.snd_l, 170);
        chk("short_ferr", bus.frame_err, 1);
      end
    end

    // I: frame error stays sticky through a good frame; stop at slot 9
    for (int i = 0; i < 9; i++) begin
      slot(i == 0, 1, 0, 1, 1, 0, 1);
      if (i == 0) begin
        chk("sticky_snd_l", bus.snd_l, 18);
        chk("sticky_ferr", bus.frame_err, 1);
      end
    end

    // zero held while cenop is low: nothing latches
    bus.zero  = 1'b1;
    bus.op    = 1'b1;
    bus.pan_l = 1'b1;
    bus.pan_r = 1'b1;
    bus.op_result = OPW'(500);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      chk("gated_vld", bus.sample_vld, 0);
      chk("gated_snd_l", bus.snd_l, 18);
    end
    bus.zero = 1'b0;

    // Asynchronous reset mid-frame, checked before any clock edge
    #2 rst = 1'b0;
    #1;
    chk("async_snd_l", bus.snd_l, 0);
    chk("async_snd_r", bus.snd_r, 0);
    chk("async_ferr", bus.frame_err, 0);
    @(posedge clk);
    #2 rst = 1'b1;
    @(posedge clk);
    #1;

    // J: additive connection slots (op=0, con=1) of 3
    for (int i = 0; i < SLOTS; i++) begin
      slot(i == 0, 0, 1, 1, 1, 0, 3);
      if (i == 0) begin
        chk("post_rst_snd_l", bus.snd_l, 0);
        chk("post_rst_ferr", bus.frame_err, 0);
        chk("post_rst_vld", bus.sample_vld, 1);
      end
    end

    // K: one slot, then an immediate second zero
    slot(1, 0, 1, 1, 1, 0, 3);
    chk("con_snd_l", bus.snd_l, 54);
    chk("con_snd_r", bus.snd_r, 54);
    chk("con_ferr", bus.frame_err, 0);
    slot(1, 0, 1, 1, 1, 0, 3);
    chk("dbl_zero_snd_l", bus.snd_l, 3);
    chk("dbl_zero_ferr", bus.frame_err, 1);
    chk("dbl_zero_vld", bus.sample_vld, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/jtopl_stereo_acc.md
Name: jtopl_stereo_acc

Overview:
- Parametrised multi-slot output accumulator for the OPL operator pipeline; successor to the mono single-sum accumulator.
- Sums carrier-operator results over one slot frame into separate left/right accumulators, with per-slot panning and rhythm gain.
- Latches saturated stereo samples at frame boundary, strobes sample-valid, flags clipping and frame-length errors.
- Sits between the operator stage and the top-level sound output.

Parameters:
- OPW, 14, signed operator result width
- OUTW, 16, signed output sample width (OUTW >= OPW)
- SLOTS, 18, operator slots per frame (>= 2)
- ACCW, OPW+6, internal accumulator width; must hold SLOTS*2*max|op_result| without wrap

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- cenop  in  1  operator clock enable; one slot per asserted cycle
- op_result  in  OPW  signed operator output for current slot
- zero  in  1  current slot is first of frame
- op  in  1  0 = modulator operator slot
- con  in  1  0 = modulated (FM) connection
- pan_l  in  1  slot contributes to left
- pan_r  in  1  slot contributes to right
- rhy  in  1  rhythm slot; contribution doubled
- snd_l  out  OUTW  signed left sample
- snd_r  out  OUTW  signed right sample
- sample_vld  out  1  one-clk pulse on sample latch
- clip  out  1  last latched sample saturated (either side)
- frame_err  out  1  sticky; frame length != SLOTS

Behaviour:
- Reset (rst low, async): snd_l, snd_r, accumulators, slot counter = 0; sample_vld, clip, frame_err = 0; first_frame = 1.
- All state changes only on clk edges with cenop = 1, except the sample_vld clear (every clk).
- sum_en = op | con.
- term = sum_en ? sext(op_result) << rhy : 0, in ACCW bits.
- tl = pan_l ? term : 0; tr = pan_r ? term : 0.
- cenop & !zero:
  - acc_l += tl; acc_r += tr.
  - cnt += 1, saturating at SLOTS.
- cenop & zero:
  - snd_x <= sat_OUTW(acc_x) for both sides; acc_x <= tx (current slot starts the new frame).
  - cnt <= 1.
  - sample_vld = 1 for exactly the next clk cycle.
  - clip <= 1 if either side saturated, else 0.
- Latency: a slot contributes to the snd sample latched at the next zero slot.
- Saturation: values > 2^(OUTW-1)-1 clamp to max; values < -2^(OUTW-1) clamp to min. No wrap permitted.
- First zero after reset: latches 0 from the cleared accumulators; frame_err not checked (first_frame cleared).
- Frame check: at each later zero, if cnt != SLOTS then frame_err <= 1. frame_err is cleared only by reset.
- Consecutive zeros: cnt = 1 != SLOTS -> frame_err set; samples still latched.
- cenop low: full hold, including on a zero slot. zero is qualified by cenop.
- pan_l = pan_r = 0: slot is discarded but still counted.
- Reset mid-frame: partial sums are discarded; the next zero latches 0 with no frame_err.

Decomposition:
- Shared jtopl package:
  - OPL slot count constant (18).
  - Function computing ACCW from OPW and SLOTS.
  - Generic signed saturate function sat(value, width), reused across jtopl blocks.
- Sub-module jtopl_sat_latch, instantiated twice (L/R):
  - inputs: acc, term, load (cenop & zero), en (cenop).
  - outputs: snd, overflow bit.
- Top level holds term/pan/rhythm logic, slot counter, sample_vld, clip, frame_err.

Test Plan:
- Basic sum: 18-slot frames, all op=1, pan_l=pan_r=1, op_result=100 -> second zero latches snd_l = snd_r = 1800; sample_vld one clk; clip=0.
- Modulator mask and pan: slots alternate op=0/con=0 (masked) and op=1 with pan_l=1, pan_r=0, value -50 -> snd_l = -450, snd_r = 0.
- Rhythm gain: one slot rhy=1, op_result=1000, other slots op_result=0 -> snd_l = 2000.
- Saturation: 18 slots of +8191 with rhy=1 (sum 294876) -> snd_l = 32767, clip=1; repeat with -8192 -> snd_l = -32768; next normal frame -> clip=0.
- Frame error: frame of 17 slots -> frame_err=1 after that zero, stays 1 through later good frames; reset clears it.
- Async reset mid-frame, and cenop gating:
  - rst low at slot 9 -> all outputs 0 immediately, no clk edge needed.
  - After release: first zero gives snd=0, frame_err=0.
  - zero held with cenop=0 for 5 clks -> no latch, no sample_vld.
